spi_cfg_reg: RTL and testbench
==============================

SPI_CFG_REG -- requirements
Module: spi_cfg_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the number of configuration bits (legal range 2..64).
REQ-002 The block SHALL have parameter RESET_VALUE, default {WIDTH{1'b0}}, giving the value of cfg_out after reset.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for the SPI inputs (legal range 2..3).
REQ-004 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all flops rise-edge triggered.
REQ-005 The block SHALL have port wb_rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port spi_csb, input, 1 bit: chip select, active low, asynchronous to wb_clk_i.
REQ-007 The block SHALL have port spi_sck, input, 1 bit: SPI mode-0 clock, idle low, asynchronous, frequency at most wb_clk_i/8.
REQ-008 The block SHALL have port spi_mosi, input, 1 bit: serial data in, MSB first.
REQ-009 The block SHALL have port spi_miso, output, 1 bit: serial readback of the current cfg_out, MSB first.
REQ-010 The block SHALL have port cfg_out, output, WIDTH bits: the committed configuration word, driven constant between commits.
REQ-011 The block SHALL have port cfg_valid, output, 1 bit: one-cycle pulse on every commit.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a discarded frame.

Function
REQ-013 The block SHALL pass spi_csb, spi_sck and spi_mosi through SYNC_STAGES-flop synchronizers, plus one history flop each on csb and sck for edge detection.
REQ-014 The block SHALL implement a three-state FSM.
- IDLE: csb_s high.
- ACTIVE: frame in progress.
- WAIT_IDLE: entered from reset; waits for csb_s high, ignores all SPI activity, then goes to IDLE.
REQ-015 The FSM SHALL go IDLE->ACTIVE on a synchronized csb falling edge, and on that edge SHALL clear the bit counter and load tx_sr with cfg_out.
REQ-016 In ACTIVE, each synchronized sck rising edge SHALL shift rx_sr <= {rx_sr[WIDTH-2:0], mosi_s} and increment the bit counter.
- The counter SHALL saturate at WIDTH+1.
- The counter width SHALL be $clog2(WIDTH+2).
REQ-017 In ACTIVE, each synchronized sck falling edge SHALL shift tx_sr left by one with zero fill.
REQ-018 spi_miso SHALL equal tx_sr[WIDTH-1] while state is ACTIVE, and 0 otherwise.
REQ-019 In ACTIVE, a synchronized csb rising edge SHALL return the FSM to IDLE and end the frame as follows.
- Counter == WIDTH: cfg_out <= rx_sr, and cfg_valid pulses high for exactly one cycle on the same edge that cfg_out updates.
- Counter == 0: no cfg_out change, no pulse.
- Any other counter value (1..WIDTH-1, or saturated WIDTH+1): cfg_out is unchanged and frame_err pulses for one cycle.
REQ-020 A csb rising edge and an sck edge detected in the same cycle: csb SHALL take priority and the sck edge is ignored.
REQ-021 sck edges detected while in IDLE or WAIT_IDLE SHALL have no effect.
REQ-022 Commit latency: cfg_out and cfg_valid SHALL update SYNC_STAGES+2 wb_clk_i rising edges after spi_csb rises at the pin, given setup is met.
REQ-023 cfg_valid and frame_err SHALL never be high in the same cycle.
REQ-024 cfg_out SHALL never change except on commit or reset, and SHALL never show a partially shifted value.

Reset
REQ-025 While wb_rst_i is high at a clock edge, the following SHALL hold on that edge.
- cfg_out = RESET_VALUE.
- cfg_valid = 0, frame_err = 0, spi_miso = 0.
- rx_sr and tx_sr = 0; counter = 0.
- csb synchronizer and history flops = 1; sck and mosi synchronizer and history flops = 0.
- State = WAIT_IDLE.
REQ-026 Reset asserted mid-frame SHALL discard the frame without pulsing either strobe. Because the FSM starts in WAIT_IDLE, bits still clocked in that frame after reset releases SHALL be ignored until csb returns high.

Verification
REQ-027 The bench SHALL cover the following directed scenarios (WIDTH=32, RESET_VALUE=32'h0000_FFFF, SYNC_STAGES=2).
- Reset, then idle -> cfg_out=32'h0000_FFFF, both strobes 0, spi_miso=0.
- 32-bit frame 32'hA5C3_0F81 at wb_clk/8 -> cfg_out=32'hA5C3_0F81 with a single cfg_valid pulse 4 edges after csb rises; spi_miso streams 32'h0000_FFFF MSB first during the frame.
- 31-bit frame, then 33-bit frame -> frame_err pulses once per frame, cfg_out unchanged, cfg_valid never pulses.
- csb low then high with no sck pulses -> no strobe, cfg_out unchanged.
- wb_rst_i pulsed after 16 bits of a frame, remaining 16 bits then sent -> cfg_out=32'h0000_FFFF, no strobe; the next full frame 32'h1234_5678 commits normally.
- Second full frame immediately after a commit -> spi_miso reads back the first committed word exactly.

Source files
------------

// File: rtl/spi_cfg_reg.sv
// SPI-loaded configuration register: receives a WIDTH-bit word over a mode-0 SPI
// slave port, commits it on a full frame and streams the current word back on miso.
module spi_cfg_reg #(
   parameter int unsigned       WIDTH       = 32,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
   parameter int unsigned       SYNC_STAGES = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             spi_csb,
   input  logic             spi_sck,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic [WIDTH-1:0] cfg_out,
   output logic             cfg_valid,
   output logic             frame_err
);

   localparam int unsigned    CW       = $clog2(WIDTH + 2);
   localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0]  CNT_SAT  = CW'(WIDTH + 1);
   localparam logic [1:0]     SETTLED  = 2'(SYNC_STAGES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_WAIT_IDLE
   } state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] csb_sync_q, sck_sync_q, mosi_sync_q;
   logic                   csb_hist_q, sck_hist_q;
   logic                   csb_rise_q, csb_fall_q, sck_rise_q, sck_fall_q;
   logic [1:0]             settle_q;
   logic                   csb_s, sck_s, mosi_s;

   logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] cfg_q, cfg_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   assign csb_s  = csb_sync_q[SYNC_STAGES-1];
   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Edge pulses are registered, so a commit lands SYNC_STAGES+2 edges after csb rises.
   // settle_q keeps WAIT_IDLE from trusting csb_s until it holds a post-reset sample.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         csb_sync_q  <= '1;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         csb_hist_q  <= 1'b1;
         sck_hist_q  <= 1'b0;
         csb_rise_q  <= 1'b0;
         csb_fall_q  <= 1'b0;
         sck_rise_q  <= 1'b0;
         sck_fall_q  <= 1'b0;
         settle_q    <= '0;
      end else begin
         csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         csb_hist_q  <= csb_s;
         sck_hist_q  <= sck_s;
         csb_rise_q  <= csb_s & ~csb_hist_q;
         csb_fall_q  <= ~csb_s & csb_hist_q;
         sck_rise_q  <= sck_s & ~sck_hist_q;
         sck_fall_q  <= ~sck_s & sck_hist_q;
         if (settle_q != SETTLED) begin
            settle_q <= settle_q + 2'd1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_WAIT_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_WAIT_IDLE: if ((settle_q == SETTLED) && csb_s) state_d = ST_IDLE;
         ST_IDLE:      if (csb_fall_q) state_d = ST_ACTIVE;
         ST_ACTIVE:    if (csb_rise_q) state_d = ST_IDLE;
         default:      state_d = ST_WAIT_IDLE;
      endcase
   end

   always_comb begin
      rx_sr_d = rx_sr_q;
      tx_sr_d = tx_sr_q;
      cnt_d   = cnt_q;
      cfg_d   = cfg_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (csb_fall_q) begin
               cnt_d   = '0;
               tx_sr_d = cfg_q;
            end
         end
         ST_ACTIVE: begin
            // csb rising wins over any sck edge seen in the same cycle
            if (csb_rise_q) begin
               if (cnt_q == CNT_FULL) begin
                  cfg_d   = rx_sr_q;
                  valid_d = 1'b1;
               end else if (cnt_q != '0) begin
                  err_d = 1'b1;
               end
            end else begin
               if (sck_rise_q) begin
                  rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi_s};
                  if (cnt_q != CNT_SAT) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               if (sck_fall_q) begin
                  tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_sr_q <= '0;
         tx_sr_q <= '0;
         cnt_q   <= '0;
         cfg_q   <= RESET_VALUE;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rx_sr_q <= rx_sr_d;
         tx_sr_q <= tx_sr_d;
         cnt_q   <= cnt_d;
         cfg_q   <= cfg_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign spi_miso  = (state_q == ST_ACTIVE) ? tx_sr_q[WIDTH-1] : 1'b0;
   assign cfg_out   = cfg_q;
   assign cfg_valid = valid_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_spi_cfg_reg.sv
// Directed bench for spi_cfg_reg: frame-level reference model checked every cycle,
// plus literal expectations after each scenario.
module tb_spi_cfg_reg;

   localparam int          W  = 32;
   localparam logic [31:0] RV = 32'h0000_FFFF;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        csb  = 1'b1;
   logic        sck  = 1'b0;
   logic        mosi = 1'b0;
   logic        miso;
   logic [31:0] cfg_out;
   logic        cfg_valid;
   logic        frame_err;

   spi_cfg_reg #(
      .WIDTH       (32),
      .RESET_VALUE (32'h0000_FFFF),
      .SYNC_STAGES (2)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .spi_csb   (csb),
      .spi_sck   (sck),
      .spi_mosi  (mosi),
      .spi_miso  (miso),
      .cfg_out   (cfg_out),
      .cfg_valid (cfg_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          n_valid = 0;
   int          n_err   = 0;
   logic [31:0] model_cfg = RV;
   int          pend_kind = 0;   // 0 none, 1 commit, 2 frame error
   int          pend_cyc  = 0;
   logic [31:0] pend_val  = '0;
   logic        exp_v, exp_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Outcome of a frame becomes visible four edges after csb rises at the pin.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rst) begin
         model_cfg = RV;
         pend_kind = 0;
      end
      exp_v = (pend_kind == 1) && (cyc == pend_cyc);
      exp_e = (pend_kind == 2) && (cyc == pend_cyc);
      if (exp_v) model_cfg = pend_val;
      check("cfg_out", cfg_out, model_cfg);
      check("cfg_valid", cfg_valid, exp_v);
      check("frame_err", frame_err, exp_e);
      check("strobe_excl", cfg_valid & frame_err, 0);
      if (rst) check("miso_rst", miso, 0);
      if (cfg_valid) n_valid++;
      if (frame_err) n_err++;
   end

   task automatic send_frame(input logic [63:0] data, input int nbits, input int rst_at);
      logic [31:0] word;
      bit          tainted;
      logic        exp_m;
      tainted = 0;
      @(negedge clk);
      word = model_cfg;
      csb  = 1'b0;
      mosi = (nbits > 0) ? data[nbits-1] : 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            tainted = 1;
            repeat (4) @(negedge clk);
         end
         mosi  = data[nbits-1-i];
         exp_m = (tainted || i >= W) ? 1'b0 : word[W-1-i];
         check("miso_bit", miso, exp_m);
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
         repeat (4) @(negedge clk);
      end
      csb = 1'b1;
      if (!tainted && nbits == W) begin
         pend_val  = data[31:0];
         pend_cyc  = cyc + 4;
         pend_kind = 1;
      end else if (!tainted && nbits != 0) begin
         pend_cyc  = cyc + 4;
         pend_kind = 2;
      end
      repeat (20) @(negedge clk);
   endtask

   int v0, e0;

   initial begin
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("reset_cfg", cfg_out, 64'h0000_FFFF);
      check("reset_miso", miso, 0);
      check("reset_strobes", n_valid + n_err, 0);

      v0 = n_valid; e0 = n_err;
      send_frame(64'hA5C3_0F81, 32, -1);
      check("f1_cfg", cfg_out, 64'hA5C3_0F81);
      check("f1_valid_cnt", n_valid - v0, 1);
      check("f1_err_cnt", n_err - e0, 0);

      v0 = n_valid; e0 = n_err;
      send_frame(64'h3C96_E1D2, 32, -1);
      check("f2_cfg", cfg_out, 64'h3C96_E1D2);
      check("f2_valid_cnt", n_valid - v0, 1);

      v0 = n_valid; e0 = n_err;
      send_frame(64'h0123_4567, 31, -1);
      check("f31_cfg", cfg_out, 64'h3C96_E1D2);
      check("f31_err_cnt", n_err - e0, 1);
      check("f31_valid_cnt", n_valid - v0, 0);

      v0 = n_valid; e0 = n_err;
      send_frame(64'h1_DEAD_BEEF, 33, -1);
      check("f33_cfg", cfg_out, 64'h3C96_E1D2);
      check("f33_err_cnt", n_err - e0, 1);
      check("f33_valid_cnt", n_valid - v0, 0);

      v0 = n_valid; e0 = n_err;
      send_frame(64'h0, 0, -1);
      check("empty_cfg", cfg_out, 64'h3C96_E1D2);
      check("empty_strobes", (n_valid - v0) + (n_err - e0), 0);

      v0 = n_valid; e0 = n_err;
      send_frame(64'hCAFE_BABE, 32, 16);
      check("rstmid_cfg", cfg_out, 64'h0000_FFFF);
      check("rstmid_strobes", (n_valid - v0) + (n_err - e0), 0);

      v0 = n_valid; e0 = n_err;
      send_frame(64'h1234_5678, 32, -1);
      check("post_rst_cfg", cfg_out, 64'h1234_5678);
      check("post_rst_valid_cnt", n_valid - v0, 1);

      send_frame(64'h0, 32, -1);
      check("last_cfg", cfg_out, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
